// File: rtl/wta_arbiter.sv
// -----------------------------------------------------------------------------
// wta_arbiter
//
// Winner-take-all arbiter for one excitatory layer of N neurons. Each neuron's
// potential adder reports the end of its pp3 accumulation with a valid pulse.
// The arbiter latches every potential once, scans them for the highest value
// (lowest index wins a tie), tests that value against the firing threshold,
// and releases all adders with a single start_pp3m_o pulse that carries a
// per-neuron won/lost/hold decision.
//
// Ports
//   clk_i               rising-edge clock
//   rst_ni              asynchronous active-low reset
//   start_core_img_i    synchronous round abort/clear (one-cycle pulse)
//   valid_pp3m_i  [N]   per-neuron "accumulation finished" pulses
//   potential_i [N*W]   packed signed potentials, neuron i at [i*W +: W]
//   threshold_i   [W]   signed firing threshold, sampled in DECIDE
//   start_pp3m_o        one-cycle release pulse to every adder
//   won_lost_hold_o [N] 1 = won/hold, 0 = lost (inhibited)
//   winner_idx_o [IDXW] index of the maximum potential of the last round
//   winner_fire_o       last round's maximum strictly exceeded the threshold
//   busy_o              high whenever the arbiter is not collecting
//   dup_err_o           sticky: a valid arrived twice in a round or while busy
// -----------------------------------------------------------------------------
// state   | meaning
// --------+-------------------------------------------------------------------
// COLLECT | latch potentials as valids arrive; wait until every neuron reported
// COMPARE | walk the latched potentials one per cycle, tracking the maximum
// DECIDE  | compare the maximum with the threshold, update decision outputs
// FIRE    | start_pp3m_o is high; clear the collection mask
// -----------------------------------------------------------------------------
module wta_arbiter #(
    parameter int N    = 8,
    parameter int W    = 32,
    parameter int IDXW = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_core_img_i,
    input  logic [N-1:0]      valid_pp3m_i,
    input  logic [N*W-1:0]    potential_i,
    input  logic [W-1:0]      threshold_i,
    output logic              start_pp3m_o,
    output logic [N-1:0]      won_lost_hold_o,
    output logic [IDXW-1:0]   winner_idx_o,
    output logic              winner_fire_o,
    output logic              busy_o,
    output logic              dup_err_o
);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_COMPARE = 2'd1,
        S_DECIDE  = 2'd2,
        S_FIRE    = 2'd3
    } state_e;

    state_e              state_q, state_d;

    logic [N-1:0]        mask_q, mask_d;
    logic signed [W-1:0] nbuf_q [N];
    logic signed [W-1:0] nbuf_d [N];
    logic [IDXW-1:0]     cidx_q, cidx_d;
    logic [IDXW-1:0]     bidx_q, bidx_d;
    logic signed [W-1:0] best_q, best_d;

    logic                start_q, start_d;
    logic [N-1:0]        wlh_q, wlh_d;
    logic [IDXW-1:0]     widx_q, widx_d;
    logic                wfire_q, wfire_d;
    logic                busy_q, busy_d;
    logic                dup_q, dup_d;

    logic [N-1:0]        fresh_valid;
    logic                repeat_valid;
    logic                collect_done;
    logic                last_cidx;
    logic signed [W-1:0] cand;
    logic signed [W-1:0] thr;

    assign fresh_valid  = valid_pp3m_i & ~mask_q;
    assign repeat_valid = |(valid_pp3m_i & mask_q);
    // The round completes on the edge that samples the last missing valid,
    // so the incoming bits are folded in rather than waiting for the mask.
    assign collect_done = &(mask_q | valid_pp3m_i);
    assign last_cidx    = (cidx_q == IDXW'(N - 1));
    assign cand         = nbuf_q[cidx_q];
    assign thr          = $signed(threshold_i);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        if (start_core_img_i) begin
            state_d = S_COLLECT;
        end else begin
            unique case (state_q)
                S_COLLECT: if (collect_done) state_d = S_COMPARE;
                S_COMPARE: if (last_cidx)    state_d = S_DECIDE;
                S_DECIDE:                    state_d = S_FIRE;
                S_FIRE:                      state_d = S_COLLECT;
                default:                     state_d = S_COLLECT;
            endcase
        end
    end

    // ------------------------------------------------- datapath and outputs
    always_comb begin
        mask_d  = mask_q;
        nbuf_d  = nbuf_q;
        cidx_d  = cidx_q;
        bidx_d  = bidx_q;
        best_d  = best_q;
        start_d = 1'b0;
        wlh_d   = wlh_q;
        widx_d  = widx_q;
        wfire_d = wfire_q;
        dup_d   = dup_q;
        busy_d  = (state_d != S_COLLECT);

        if (start_core_img_i) begin
            // Abort wins over everything, including a same-cycle valid.
            mask_d  = '0;
            wlh_d   = '0;
            widx_d  = '0;
            wfire_d = 1'b0;
            dup_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_COLLECT: begin
                    for (int i = 0; i < N; i++) begin
                        if (fresh_valid[i]) begin
                            nbuf_d[i] = potential_i[i*W +: W];
                        end
                    end
                    mask_d = mask_q | valid_pp3m_i;
                    if (repeat_valid) dup_d = 1'b1;
                    if (collect_done) begin
                        // Seed the scan with neuron 0, which may be landing
                        // in the buffer on this very edge.
                        cidx_d = '0;
                        bidx_d = '0;
                        best_d = nbuf_d[0];
                    end
                end
                S_COMPARE: begin
                    if (|valid_pp3m_i) dup_d = 1'b1;
                    // Strict compare keeps the lowest index on a tie.
                    if (cand > best_q) begin
                        best_d = cand;
                        bidx_d = cidx_q;
                    end
                    cidx_d = cidx_q + IDXW'(1);
                end
                S_DECIDE: begin
                    if (|valid_pp3m_i) dup_d = 1'b1;
                    widx_d  = bidx_q;
                    start_d = 1'b1;
                    if (best_q > thr) begin
                        wlh_d         = '0;
                        wlh_d[bidx_q] = 1'b1;
                        wfire_d       = 1'b1;
                    end else begin
                        // No neuron fires: all hold and leak normally.
                        wlh_d   = '1;
                        wfire_d = 1'b0;
                    end
                end
                S_FIRE: begin
                    if (|valid_pp3m_i) dup_d = 1'b1;
                    mask_d = '0;
                end
                default: begin
                    mask_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mask_q  <= '0;
            cidx_q  <= '0;
            bidx_q  <= '0;
            best_q  <= '0;
            start_q <= 1'b0;
            wlh_q   <= '0;
            widx_q  <= '0;
            wfire_q <= 1'b0;
            busy_q  <= 1'b0;
            dup_q   <= 1'b0;
        end else begin
            mask_q  <= mask_d;
            cidx_q  <= cidx_d;
            bidx_q  <= bidx_d;
            best_q  <= best_d;
            start_q <= start_d;
            wlh_q   <= wlh_d;
            widx_q  <= widx_d;
            wfire_q <= wfire_d;
            busy_q  <= busy_d;
            dup_q   <= dup_d;
        end
    end

    // Potential buffer contents are only meaningful under the mask, so it
    // carries no reset.
    always_ff @(posedge clk_i) begin
        nbuf_q <= nbuf_d;
    end

    assign start_pp3m_o    = start_q;
    assign won_lost_hold_o = wlh_q;
    assign winner_idx_o    = widx_q;
    assign winner_fire_o   = wfire_q;
    assign busy_o          = busy_q;
    assign dup_err_o       = dup_q;

endmodule

// File: tb/tb_wta_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wta_arbiter
//
// Drives directed and random pp3 rounds into wta_arbiter. Each completed round
// pushes its expected decision (from a max/threshold model over the first
// accepted potential of every neuron) into a queue; a monitor pops and checks
// whenever start_pp3m_o is seen high, including the edge on which it arrives.
// -----------------------------------------------------------------------------
module tb_wta_arbiter;

    localparam int N    = 8;
    localparam int W    = 32;
    localparam int IDXW = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_core_img = 1'b0;
    logic [N-1:0]      valid = '0;
    logic [N*W-1:0]    potential = '0;
    logic [W-1:0]      threshold = '0;
    logic              start_pp3m;
    logic [N-1:0]      won_lost_hold;
    logic [IDXW-1:0]   winner_idx;
    logic              winner_fire;
    logic              busy;
    logic              dup_err;

    wta_arbiter #(.N(N), .W(W), .IDXW(IDXW)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .start_core_img_i (start_core_img),
        .valid_pp3m_i     (valid),
        .potential_i      (potential),
        .threshold_i      (threshold),
        .start_pp3m_o     (start_pp3m),
        .won_lost_hold_o  (won_lost_hold),
        .winner_idx_o     (winner_idx),
        .winner_fire_o    (winner_fire),
        .busy_o           (busy),
        .dup_err_o        (dup_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]    wlh;
        logic [IDXW-1:0] idx;
        logic            fire;
        longint          edge_no;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    longint       edge_cnt = 0;
    int           total = 0;
    int           bad = 0;

    int           stim [N];
    int           mbuf [N];
    logic [N-1:0] mmask = '0;
    logic         mdup = 1'b0;
    int           mthr = 0;
    logic [N-1:0] rnd_v;
    int           cyc;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Max over the round, lowest index holding that max, strict threshold.
    function automatic exp_t model_result(input longint e_no);
        exp_t r;
        int   mx;
        mx = mbuf[0];
        for (int i = 1; i < N; i++) if (mbuf[i] > mx) mx = mbuf[i];
        r.idx = '0;
        for (int i = N - 1; i >= 0; i--) if (mbuf[i] == mx) r.idx = IDXW'(i);
        r.fire = (mx > mthr);
        if (r.fire) begin
            r.wlh        = '0;
            r.wlh[r.idx] = 1'b1;
        end else begin
            r.wlh = '1;
        end
        r.edge_no = e_no;
        return r;
    endfunction

    // Called just after a rising edge: applies inputs that the next edge samples,
    // updates the model, then returns 2 time units after that next edge.
    task automatic drive(input logic [N-1:0] v, input logic abort);
        logic busy_m;
        for (int i = 0; i < N; i++) begin
            potential[i*W +: W] = $urandom;
            if (v[i]) potential[i*W +: W] = stim[i];
        end
        valid          = v;
        start_core_img = abort;
        threshold      = mthr;
        busy_m         = (exp_q.size() != 0);
        if (abort) begin
            mmask = '0;
            mdup  = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (v[i]) begin
                    if (busy_m || mmask[i]) begin
                        mdup = 1'b1;
                    end else begin
                        mbuf[i]  = stim[i];
                        mmask[i] = 1'b1;
                    end
                end
            end
            if (!busy_m && (&mmask)) begin
                // Sampling edge is edge_cnt+1; pulse seen N+1 edges later.
                exp_q.push_back(model_result(edge_cnt + N + 2));
                mmask = '0;
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input bit inject);
        int n = 0;
        if (inject && exp_q.size() != 0) begin
            rnd_v = '0;
            rnd_v[$urandom_range(0, N - 1)] = 1'b1;
            drive(rnd_v, 1'b0);
            n++;
        end
        while (exp_q.size() != 0 && n < 4 * N) begin
            drive('0, 1'b0);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: start_pp3m not seen, pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        chk("dup_err_after_round", dup_err, mdup);
        chk("busy_after_round", busy, 0);
    endtask

    function automatic int rand_pot();
        case ($urandom_range(0, 3))
            0:       return 30000;
            1:       return int'($urandom_range(0, 4)) * 1000 - 2000;
            default: return int'($urandom_range(0, 80000)) - 40000;
        endcase
    endfunction

    task automatic set_stim(input int a0, input int a1, input int a2, input int a3,
                            input int a4, input int a5, input int a6, input int a7);
        stim[0] = a0; stim[1] = a1; stim[2] = a2; stim[3] = a3;
        stim[4] = a4; stim[5] = a5; stim[6] = a6; stim[7] = a7;
    endtask

    // Monitor: every start pulse must match the oldest outstanding round.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && start_pp3m !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_start: start_pp3m=%b at edge %0d, required 0", start_pp3m, edge_cnt);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("won_lost_hold", won_lost_hold, mon_e.wlh);
                    chk("winner_idx", winner_idx, mon_e.idx);
                    chk("winner_fire", winner_fire, mon_e.fire);
                    chk("start_edge", edge_cnt, mon_e.edge_no);
                    chk("busy_in_fire", busy, 1);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            stim[i] = 0;
            mbuf[i] = 0;
        end

        // Reset values
        repeat (3) @(posedge clk);
        #2;
        chk("rst_start", start_pp3m, 0);
        chk("rst_wlh", won_lost_hold, 0);
        chk("rst_idx", winner_idx, 0);
        chk("rst_fire", winner_fire, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dup", dup_err, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Single winner, staggered valids
        mthr = 15018;
        set_stim(1000, 20000, 5000, 0, -300, 19999, 7, 15018);
        for (int i = 0; i < N; i++) begin
            rnd_v = '0;
            rnd_v[i] = 1'b1;
            drive(rnd_v, 1'b0);
        end
        wait_done(1'b0);
        repeat (3) drive('0, 1'b0);
        chk("hold_wlh", won_lost_hold, 8'h02);
        chk("hold_idx", winner_idx, 1);
        chk("hold_fire", winner_fire, 1);

        // No winner: max equals threshold, all valids in one cycle
        set_stim(1000, 2000, -50, 0, 15017, 3, 15000, 15018);
        drive('1, 1'b0);
        wait_done(1'b0);

        // Tie and negatives
        set_stim(-5, 30000, 30000, -500 * 4096, -1, 0, 29999, -500 * 4096);
        drive(8'h0F, 1'b0);
        drive(8'hF0, 1'b0);
        wait_done(1'b0);

        // Abort after 5 valids, then a fresh full round
        set_stim(1000, 20000, 5000, 0, -300, 19999, 7, 15018);
        for (int i = 0; i < 5; i++) begin
            rnd_v = '0;
            rnd_v[i] = 1'b1;
            drive(rnd_v, 1'b0);
        end
        drive('0, 1'b1);
        chk("abort_wlh", won_lost_hold, 0);
        chk("abort_idx", winner_idx, 0);
        chk("abort_fire", winner_fire, 0);
        chk("abort_busy", busy, 0);
        for (int i = 0; i < N; i++) begin
            rnd_v = '0;
            rnd_v[i] = 1'b1;
            drive(rnd_v, 1'b0);
        end
        wait_done(1'b0);

        // Abort coincident with a valid drops that valid
        stim[2] = 999999;
        drive(8'h04, 1'b1);
        stim[2] = 5000;
        drive(8'hFB, 1'b0);
        drive(8'h04, 1'b0);
        wait_done(1'b0);

        // Duplicate valid: first value kept, dup_err sticky until abort
        set_stim(10, 20, 30, 100, 40, 50, -60, 0);
        drive(8'h08, 1'b0);
        stim[3] = 40000;
        drive(8'h08, 1'b0);
        drive(8'hF7, 1'b0);
        wait_done(1'b0);
        set_stim(1, 2, 3, 4, 5, 6, 7, 8);
        drive('1, 1'b0);
        wait_done(1'b0);
        drive('0, 1'b1);
        chk("dup_cleared_by_abort", dup_err, 0);

        // Reset during COMPARE, with dup_err set by a valid while busy
        set_stim(50000, 1, 2, 3, 4, 5, 6, 7);
        drive('1, 1'b0);
        drive(8'h01, 1'b0);
        drive('0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        exp_q.delete();
        mmask = '0;
        mdup  = 1'b0;
        chk("midrst_start", start_pp3m, 0);
        chk("midrst_wlh", won_lost_hold, 0);
        chk("midrst_idx", winner_idx, 0);
        chk("midrst_fire", winner_fire, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_dup", dup_err, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (N + 4) drive('0, 1'b0);
        chk("post_rst_busy", busy, 0);

        // Random rounds
        for (int r = 0; r < 40; r++) begin
            mthr = int'($urandom_range(0, 60000)) - 30000;
            cyc  = 0;
            while (exp_q.size() == 0 && cyc < 20) begin
                for (int i = 0; i < N; i++) stim[i] = rand_pot();
                rnd_v = N'($urandom) & ~mmask;
                if ($urandom_range(0, 2) == 0) rnd_v = '0;
                if (cyc >= 5) rnd_v = ~mmask;
                if ($urandom_range(0, 9) == 0) rnd_v = rnd_v | (mmask & N'($urandom));
                drive(rnd_v, 1'b0);
                cyc++;
            end
            wait_done($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) begin
                drive('0, 1'b1);
                chk("rand_abort_dup", dup_err, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
